// File: rtl/ej32_pkg.sv
// ej32_pkg: shared types and constants for the eJ32 ALU extension sequencer.
// Contents:
//   DSZ_DEF      default datapath width
//   DIV_LAT      accept-to-done latency of a divide, in cycles
//   alu_ext_op_t request opcode (MUL, MULH, DIV, REM, UDIV, UREM)
//   alu_ext_st_t sequencer state
package ej32_pkg;

  localparam int DSZ_DEF = 32;

  // The accept cycle counts as cycle 0, so done is seen in cycle DSZ+2.
  localparam int DIV_LAT = DSZ_DEF + 2;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_MULH = 3'd1,
    OP_DIV  = 3'd2,
    OP_REM  = 3'd3,
    OP_UDIV = 3'd4,
    OP_UREM = 3'd5
  } alu_ext_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL    = 3'd1,
    S_ZERO   = 3'd2,
    S_DSTART = 3'd3,
    S_DWAIT  = 3'd4,
    S_DONE   = 3'd5
  } alu_ext_st_t;

endpackage

// File: rtl/div_int.sv
// div_int: iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk    in  1     clock
//   start  in  1     load x/y and begin; one cycle wide
//   x      in  DSZ   dividend
//   y      in  DSZ   divisor (never zero when started)
//   busy   out 1     iterations still in progress
//   q      out DSZ   quotient, valid once busy drops
//   r      out DSZ   remainder, valid once busy drops
// The unit has no reset: a new start always reloads it, and busy is only
// looked at while a divide started by the sequencer is outstanding.
module div_int
  import ej32_pkg::*;
#(
  parameter int DSZ = DSZ_DEF
) (
  input  logic           clk,
  input  logic           start,
  input  logic [DSZ-1:0] x,
  input  logic [DSZ-1:0] y,
  output logic           busy,
  output logic [DSZ-1:0] q,
  output logic [DSZ-1:0] r
);

  localparam int CW = $clog2(DSZ + 1);

  logic [DSZ-1:0] y_q;
  logic [CW-1:0]  cnt;
  logic [DSZ-1:0] r_cur;
  logic [DSZ-1:0] q_cur;
  logic [DSZ-1:0] y_cur;
  logic [DSZ:0]   r_sh;
  logic [DSZ:0]   diff;
  logic [DSZ-1:0] r_nxt;
  logic [DSZ-1:0] q_nxt;

  // One restoring step. On the start cycle the step works straight from the
  // inputs, so the first quotient bit is produced on the load edge itself.
  always_comb begin
    r_cur = start ? '0 : r;
    q_cur = start ? x  : q;
    y_cur = start ? y  : y_q;
    r_sh  = {r_cur, q_cur[DSZ-1]};
    diff  = r_sh - {1'b0, y_cur};
    if (!diff[DSZ]) begin
      r_nxt = diff[DSZ-1:0];
      q_nxt = {q_cur[DSZ-2:0], 1'b1};
    end else begin
      r_nxt = r_sh[DSZ-1:0];
      q_nxt = {q_cur[DSZ-2:0], 1'b0};
    end
  end

  // Load performs step 1; the remaining DSZ-1 steps run while busy.
  always_ff @(posedge clk) begin
    if (start) begin
      y_q  <= y;
      r    <= r_nxt;
      q    <= q_nxt;
      cnt  <= CW'(DSZ - 1);
      busy <= 1'b1;
    end else if (busy) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mult.sv
// mult: combinational unsigned DSZ x DSZ multiplier producing the full
// 2*DSZ-bit product. Signs are handled by the sequencer.
// Ports:
//   a  in  DSZ     multiplicand magnitude
//   b  in  DSZ     multiplier magnitude
//   p  out 2*DSZ   unsigned product
module mult
  import ej32_pkg::*;
#(
  parameter int DSZ = DSZ_DEF
) (
  input  logic [DSZ-1:0]   a,
  input  logic [DSZ-1:0]   b,
  output logic [2*DSZ-1:0] p
);

  // Both operands are zero-extended so the multiply is done at full width.
  assign p = {{DSZ{1'b0}}, a} * {{DSZ{1'b0}}, b};

endmodule

// File: rtl/alu_ext_seq.sv
// alu_ext_seq: sequencer for the eJ32 ALU extension units. Takes one
// MUL/MULH/DIV/REM/UDIV/UREM request at a time, runs it on the unsigned
// multiplier or the iterative divider, applies Java signed semantics, and
// returns the result with a one-cycle done pulse.
// Ports:
//   clk   in  1    clock
//   rst   in  1    synchronous active-high reset
//   req   in  1    request valid, sampled only while rdy=1
//   op    in  3    alu_ext_op_t opcode
//   a     in  DSZ  dividend / multiplicand
//   b     in  DSZ  divisor / multiplier
//   rdy   out 1    idle; request accepted on a req&rdy edge
//   done  out 1    one-cycle pulse, res/dz valid
//   res   out DSZ  result, held until the next done
//   dz    out 1    divide-by-zero flag, held until the next done
module alu_ext_seq
  import ej32_pkg::*;
#(
  parameter int DSZ = DSZ_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [2:0]     op,
  input  logic [DSZ-1:0] a,
  input  logic [DSZ-1:0] b,
  output logic           rdy,
  output logic           done,
  output logic [DSZ-1:0] res,
  output logic           dz
);

  alu_ext_st_t    state;
  alu_ext_op_t    op_q;
  logic [DSZ-1:0] a_mag;
  logic [DSZ-1:0] b_mag;
  logic           a_neg;
  logic           b_neg;

  alu_ext_op_t    op_in;
  logic           is_signed;
  logic           is_div;
  logic [DSZ-1:0] a_abs;
  logic [DSZ-1:0] b_abs;

  logic [2*DSZ-1:0] prod;
  logic [2*DSZ-1:0] prod_fix;
  logic             div_start;
  logic             div_busy;
  logic [DSZ-1:0]   div_q;
  logic [DSZ-1:0]   div_r;
  logic [DSZ-1:0]   q_fix;
  logic [DSZ-1:0]   r_fix;

  // Decode the incoming request and form operand magnitudes. The most
  // negative value maps onto itself, which is the correct unsigned magnitude.
  always_comb begin
    op_in     = alu_ext_op_t'(op);
    is_signed = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                (op_in == OP_DIV) || (op_in == OP_REM);
    is_div    = (op_in == OP_DIV)  || (op_in == OP_REM) ||
                (op_in == OP_UDIV) || (op_in == OP_UREM);
    a_abs     = (is_signed && a[DSZ-1]) ? -a : a;
    b_abs     = (is_signed && b[DSZ-1]) ? -b : b;
  end

  // Restore signs on the unsigned results. Quotient truncates toward zero and
  // the remainder follows the dividend, so MIN/-1 wraps back to MIN.
  always_comb begin
    prod_fix = (a_neg ^ b_neg) ? -prod  : prod;
    q_fix    = (a_neg ^ b_neg) ? -div_q : div_q;
    r_fix    = a_neg ? -div_r : div_r;
  end

  mult #(.DSZ(DSZ)) u_mult (
    .a (a_mag),
    .b (b_mag),
    .p (prod)
  );

  div_int #(.DSZ(DSZ)) u_div (
    .clk   (clk),
    .start (div_start),
    .x     (a_mag),
    .y     (b_mag),
    .busy  (div_busy),
    .q     (div_q),
    .r     (div_r)
  );

  // Sequencer FSM with registered rdy/done/div_start. div_start is raised
  // on the accept edge so it is high for exactly the DSTART cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rdy       <= 1'b1;
      done      <= 1'b0;
      res       <= '0;
      dz        <= 1'b0;
      div_start <= 1'b0;
      op_q      <= OP_MUL;
      a_mag     <= '0;
      b_mag     <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
    end else begin
      done      <= 1'b0;
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            op_q  <= op_in;
            a_mag <= a_abs;
            b_mag <= b_abs;
            a_neg <= is_signed & a[DSZ-1];
            b_neg <= is_signed & b[DSZ-1];
            rdy   <= 1'b0;
            if (is_div && (b == '0)) begin
              state <= S_ZERO;
            end else if (is_div) begin
              state     <= S_DSTART;
              div_start <= 1'b1;
            end else begin
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          res   <= (op_q == OP_MULH) ? prod_fix[2*DSZ-1:DSZ] : prod_fix[DSZ-1:0];
          dz    <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_ZERO: begin
          res   <= '0;
          dz    <= 1'b1;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DSTART: begin
          state <= S_DWAIT;
        end
        S_DWAIT: begin
          if (!div_busy) begin
            res   <= ((op_q == OP_DIV) || (op_q == OP_UDIV)) ? q_fix : r_fix;
            dz    <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          rdy   <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          rdy   <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ext_seq.sv
// tb_alu_ext_seq: directed self-checking bench for alu_ext_seq (DSZ=32).
// Each step issues one request, measures the cycle in which done appears
// (accept cycle = 0), and compares result, flag and handshake against
// hand-computed values.
module tb_alu_ext_seq;

  logic        clk;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rdy;
  logic        done;
  logic [31:0] res;
  logic        dz;

  int checks;
  int failures;

  int          lat;
  int          rdy_low;
  int          pulses;
  logic [31:0] got_res;
  logic        got_dz;

  localparam logic [2:0] C_MUL  = 3'd0;
  localparam logic [2:0] C_MULH = 3'd1;
  localparam logic [2:0] C_DIV  = 3'd2;
  localparam logic [2:0] C_REM  = 3'd3;
  localparam logic [2:0] C_UDIV = 3'd4;
  localparam logic [2:0] C_UREM = 3'd5;

  alu_ext_seq #(.DSZ(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .op   (op),
    .a    (a),
    .b    (b),
    .rdy  (rdy),
    .done (done),
    .res  (res),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one request at a negedge, let it be accepted, then watch for done.
  // lat is the cycle (accept cycle = 0) in which done is seen; 999 on timeout.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] va,
                               input logic [31:0] vb, input bit hold);
    @(negedge clk);
    req = 1'b1;
    op  = o;
    a   = va;
    b   = vb;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    lat     = 999;
    rdy_low = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (!rdy) rdy_low++;
      if (done) begin
        lat     = n;
        got_res = res;
        got_dz  = dz;
        req     = 1'b0;
        break;
      end
    end
    req = 1'b0;
  endtask

  // Count done pulses over a window of cycles with no request pending.
  task automatic countPulses(input int cycles);
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    req = 1'b0;
    op  = 3'd0;
    a   = '0;
    b   = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rdy",  32'(rdy),  32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_res",  res,       32'd0);
    checkOutput("reset_dz",   32'(dz),   32'd0);

    // MUL 7 * -3 = -21
    applyStimulus(C_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
    checkOutput("mul_lat",     32'(lat),     32'd2);
    checkOutput("mul_res",     got_res,      32'hFFFF_FFEB);
    checkOutput("mul_dz",      32'(got_dz),  32'd0);
    checkOutput("mul_rdy_low", 32'(rdy_low), 32'd2);
    @(negedge clk);
    checkOutput("mul_rdy_back", 32'(rdy),  32'd1);
    checkOutput("mul_done_1cy", 32'(done), 32'd0);

    // MULH: -2^31 * 2 = -2^32 ; 2^16 * 2^16 = 2^32
    applyStimulus(C_MULH, 32'h8000_0000, 32'd2, 1'b0);
    checkOutput("mulh_neg_res", got_res, 32'hFFFF_FFFF);
    applyStimulus(C_MULH, 32'h0001_0000, 32'h0001_0000, 1'b0);
    checkOutput("mulh_pos_res", got_res, 32'h0000_0001);

    // Signed / unsigned divide
    applyStimulus(C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("div_lat", 32'(lat),    32'd34);
    checkOutput("div_res", got_res,     32'hFFFF_FFFD);
    checkOutput("div_dz",  32'(got_dz), 32'd0);
    applyStimulus(C_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkOutput("rem_res", got_res, 32'hFFFF_FFFF);
    applyStimulus(C_UDIV, 32'hFFFF_FFFF, 32'd2, 1'b0);
    checkOutput("udiv_res", got_res, 32'h7FFF_FFFF);
    applyStimulus(C_UREM, 32'd100, 32'd7, 1'b0);
    checkOutput("urem_res", got_res, 32'd2);

    // MIN / -1 overflow case
    applyStimulus(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checkOutput("divmin_res", got_res,     32'h8000_0000);
    checkOutput("divmin_dz",  32'(got_dz), 32'd0);
    applyStimulus(C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checkOutput("remmin_res", got_res, 32'd0);

    // Divide by zero, then a MUL clears the flag
    applyStimulus(C_DIV, 32'd5, 32'd0, 1'b0);
    checkOutput("dz_div_lat", 32'(lat),    32'd2);
    checkOutput("dz_div_res", got_res,     32'd0);
    checkOutput("dz_div_dz",  32'(got_dz), 32'd1);
    applyStimulus(C_UREM, 32'd9, 32'd0, 1'b0);
    checkOutput("dz_urem_res", got_res,     32'd0);
    checkOutput("dz_urem_dz",  32'(got_dz), 32'd1);
    applyStimulus(C_MUL, 32'd3, 32'd4, 1'b0);
    checkOutput("dz_clear_res", got_res,     32'd12);
    checkOutput("dz_clear_dz",  32'(got_dz), 32'd0);

    // Reset in the middle of a divide
    @(negedge clk);
    req = 1'b1;
    op  = C_DIV;
    a   = 32'd100;
    b   = 32'd7;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_rdy",  32'(rdy),  32'd1);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_res",  res,       32'd0);
    checkOutput("midrst_dz",   32'(dz),   32'd0);
    countPulses(40);
    checkOutput("midrst_no_pulse", 32'(pulses), 32'd0);

    // New divide after reset with req held high while busy
    applyStimulus(C_DIV, 32'd20, 32'd6, 1'b1);
    checkOutput("hold_lat", 32'(lat), 32'd34);
    checkOutput("hold_res", got_res,  32'd3);
    countPulses(40);
    checkOutput("hold_single_op", 32'(pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
